// File: rtl/common_p.sv
// Shared clocking types for blocks that take a single clock-domain bundle.
package common_p;

    typedef struct packed {
        logic clk;
        logic rst_n;
    } clk_dom_s;

endpackage

// File: rtl/lock_hysteresis_monitor_pkg.sv
// Lock-state encoding and CSR field placement for the lock hysteresis monitor.
package lock_monitor_p;

    typedef enum logic [1:0] {
        UNLOCKED  = 2'd0,
        ACQUIRING = 2'd1,
        LOCKED    = 2'd2,
        RELEASING = 2'd3
    } lock_state_e;

    // CSR field for state_o: the raw enum value, placed at the bottom of the word.
    localparam int unsigned STATE_CSR_WIDTH = 2;
    localparam int unsigned STATE_CSR_LSB   = 0;

    function automatic logic state_is_locked(lock_state_e s);
        return (s == LOCKED) || (s == RELEASING);
    endfunction

endpackage

// File: rtl/lock_hysteresis_monitor_if.sv
// Configuration and status bundle of the lock hysteresis monitor.
interface lock_hysteresis_monitor_if #(
    parameter int unsigned BIT_WIDTH   = 8,
    parameter int unsigned DWELL_WIDTH = 8
);
    logic                   monitor_en;
    logic                   clear_en;
    logic [BIT_WIDTH-1:0]   count;
    logic [BIT_WIDTH-1:0]   lock_threshold;
    logic [BIT_WIDTH-1:0]   unlock_threshold;
    logic [DWELL_WIDTH-1:0] acquire_dwell;
    logic [DWELL_WIDTH-1:0] release_dwell;
    logic                   locked;
    logic [1:0]             state;
    logic                   lock_event;
    logic                   unlock_event;
    logic [BIT_WIDTH-1:0]   lock_loss_count;

    // master: the controller that configures the monitor and reads its status.
    modport master (
        output monitor_en, clear_en, count, lock_threshold, unlock_threshold,
               acquire_dwell, release_dwell,
        input  locked, state, lock_event, unlock_event, lock_loss_count
    );

    modport slave (
        input  monitor_en, clear_en, count, lock_threshold, unlock_threshold,
               acquire_dwell, release_dwell,
        output locked, state, lock_event, unlock_event, lock_loss_count
    );
endinterface

// File: rtl/lock_hysteresis_monitor_dwell_timer.sv
// Dwell timer shared by the acquire and release phases; match compares against the live target.
module dwell_timer #(
    parameter int unsigned DWELL_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inc_i,
    input  logic                   clr_i,
    input  logic [DWELL_WIDTH-1:0] target_i,
    output logic                   match_o
);

    logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        dwell_d = dwell_q;
        if (clr_i) begin
            dwell_d = '0;
        end else if (inc_i) begin
            dwell_d = dwell_q + DWELL_WIDTH'(1);
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q <= '0;
        end else begin
            dwell_q <= dwell_d;
        end
    end

    assign match_o = (dwell_q == target_i);

endmodule

// File: rtl/lock_hysteresis_monitor.sv
// Debounced lock/unlock decision from a confidence count, using two thresholds and two dwell times.
module lock_hysteresis_monitor
    import common_p::*;
    import lock_monitor_p::*;
#(
    parameter int unsigned BIT_WIDTH   = 8,
    parameter int unsigned DWELL_WIDTH = 8
) (
    input  clk_dom_s               sys_dom_i,
    input  logic                   monitor_en_i,
    input  logic                   clear_en_i,
    input  logic [BIT_WIDTH-1:0]   count_i,
    input  logic [BIT_WIDTH-1:0]   lock_threshold_i,
    input  logic [BIT_WIDTH-1:0]   unlock_threshold_i,
    input  logic [DWELL_WIDTH-1:0] acquire_dwell_i,
    input  logic [DWELL_WIDTH-1:0] release_dwell_i,
    output logic                   locked_o,
    output logic [1:0]             state_o,
    output logic                   lock_event_o,
    output logic                   unlock_event_o,
    output logic [BIT_WIDTH-1:0]   lock_loss_count_o
);

    logic clk;
    logic rst_n;
    assign clk   = sys_dom_i.clk;
    assign rst_n = sys_dom_i.rst_n;

    lock_state_e            state_q, state_d;
    logic                   locked_q, locked_d;
    logic                   lock_ev_q, lock_ev_d;
    logic                   unlock_ev_q, unlock_ev_d;
    logic [BIT_WIDTH-1:0]   loss_q, loss_d;

    logic                   hi, lo;
    logic                   dwell_inc, dwell_clr, dwell_match;
    logic [DWELL_WIDTH-1:0] dwell_target;

    assign hi = (count_i >= lock_threshold_i);
    assign lo = (count_i <  unlock_threshold_i);

    // Only one dwell phase is active at a time, so the target follows the state.
    assign dwell_target = (state_q == RELEASING) ? release_dwell_i : acquire_dwell_i;

    dwell_timer #(
        .DWELL_WIDTH (DWELL_WIDTH)
    ) u_dwell_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc_i    (dwell_inc),
        .clr_i    (dwell_clr),
        .target_i (dwell_target),
        .match_o  (dwell_match)
    );

    always_comb begin
        state_d     = state_q;
        loss_d      = loss_q;
        lock_ev_d   = 1'b0;
        unlock_ev_d = 1'b0;
        dwell_inc   = 1'b0;
        dwell_clr   = 1'b0;

        if (clear_en_i) begin
            state_d   = UNLOCKED;
            loss_d    = '0;
            dwell_clr = 1'b1;
        end else if (monitor_en_i) begin
            unique case (state_q)
                UNLOCKED: begin
                    if (hi) begin
                        state_d   = ACQUIRING;
                        dwell_clr = 1'b1;
                    end
                end
                ACQUIRING: begin
                    if (!hi) begin
                        state_d   = UNLOCKED;
                        dwell_clr = 1'b1;
                    end else if (dwell_match) begin
                        state_d   = LOCKED;
                        dwell_clr = 1'b1;
                        lock_ev_d = 1'b1;
                    end else begin
                        dwell_inc = 1'b1;
                    end
                end
                LOCKED: begin
                    if (lo) begin
                        state_d   = RELEASING;
                        dwell_clr = 1'b1;
                    end
                end
                RELEASING: begin
                    if (!lo) begin
                        state_d   = LOCKED;
                        dwell_clr = 1'b1;
                    end else if (dwell_match) begin
                        state_d     = UNLOCKED;
                        dwell_clr   = 1'b1;
                        unlock_ev_d = 1'b1;
                        if (!(&loss_q)) begin
                            loss_d = loss_q + BIT_WIDTH'(1);
                        end
                    end else begin
                        dwell_inc = 1'b1;
                    end
                end
                default: begin
                    state_d   = UNLOCKED;
                    dwell_clr = 1'b1;
                end
            endcase
        end

        locked_d = state_is_locked(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= UNLOCKED;
            locked_q    <= 1'b0;
            lock_ev_q   <= 1'b0;
            unlock_ev_q <= 1'b0;
            loss_q      <= '0;
        end else begin
            state_q     <= state_d;
            locked_q    <= locked_d;
            lock_ev_q   <= lock_ev_d;
            unlock_ev_q <= unlock_ev_d;
            loss_q      <= loss_d;
        end
    end

    assign locked_o          = locked_q;
    assign state_o           = state_q;
    assign lock_event_o      = lock_ev_q;
    assign unlock_event_o    = unlock_ev_q;
    assign lock_loss_count_o = loss_q;

endmodule

// File: doc/lock_hysteresis_monitor.md
Name: lock_hysteresis_monitor

Overview:
Consumes the confidence count produced by the decaying saturation counter in the clock-recovery path. Turns it into a debounced lock/unlock decision using two thresholds (hysteresis) and two dwell timers. Emits a level lock flag, single-cycle lock/unlock event pulses, and a saturating lock-loss statistic for status/CSR logic.

Parameters:
BIT_WIDTH, 8, width of count_i, both thresholds and lock_loss_count_o.
DWELL_WIDTH, 8, width of the dwell configuration inputs and the internal dwell timer.

Ports:
sys_dom_i  input  common_p::clk_dom_s  clock domain bundle: single clock, asynchronous active-low reset
monitor_en_i  input  1  evaluation enable; low freezes all state
clear_en_i  input  1  synchronous clear; priority over everything except reset
count_i  input  BIT_WIDTH  confidence count from the saturation counter
lock_threshold_i  input  BIT_WIDTH  count_i >= this qualifies lock
unlock_threshold_i  input  BIT_WIDTH  count_i < this qualifies loss of lock
acquire_dwell_i  input  DWELL_WIDTH  extra qualifying cycles required before lock
release_dwell_i  input  DWELL_WIDTH  extra disqualifying cycles required before unlock
locked_o  output  1  registered; high in LOCKED and RELEASING
state_o  output  2  registered lock_state_e encoding
lock_event_o  output  1  one-cycle pulse on the ACQUIRING->LOCKED transition
unlock_event_o  output  1  one-cycle pulse on the RELEASING->UNLOCKED transition
lock_loss_count_o  output  BIT_WIDTH  saturating count of unlock events

Behaviour:
- Reset (async, active-low): state UNLOCKED (0), dwell 0, locked_o 0, both events 0, lock_loss_count_o 0.
- States: UNLOCKED=0, ACQUIRING=1, LOCKED=2, RELEASING=3. All outputs are registered. Compares use the current-cycle inputs, so threshold changes take effect immediately.
- hi = (count_i >= lock_threshold_i); lo = (count_i < unlock_threshold_i). Compares are unsigned.
- UNLOCKED: if hi, go to ACQUIRING with dwell=0.
- ACQUIRING:
  - If !hi, go to UNLOCKED with dwell=0.
  - Else if dwell == acquire_dwell_i, go to LOCKED, dwell=0, pulse lock_event_o.
  - Else dwell++.
- LOCKED: if lo, go to RELEASING with dwell=0.
- RELEASING:
  - If !lo, go back to LOCKED with dwell=0 and no event.
  - Else if dwell == release_dwell_i, go to UNLOCKED, dwell=0, pulse unlock_event_o, lock_loss_count_o++ (saturates at all-ones).
  - Else dwell++.
- Latency: hi first sampled at edge N gives ACQUIRING after edge N. If hi holds, LOCKED and lock_event_o appear after edge N+1+acquire_dwell_i. A dwell of 0 therefore means a 2-edge path. Release is symmetric.
- The dwell timer never exceeds the configured dwell, because the compare is equality against the live value. If the dwell config is lowered below the current dwell mid-count, the timer wraps and eventually matches; this is accepted.
- monitor_en_i=0: state, dwell and loss counter hold; events are 0.
- clear_en_i=1: next state is UNLOCKED, dwell 0, loss counter 0, no events, even if the state was LOCKED. It applies regardless of monitor_en_i.
- unlock_threshold_i > lock_threshold_i (no hysteresis) is legal. The rules above are applied literally; no special handling.
- Events are mutually exclusive and never high for two consecutive cycles from the same transition.

Decomposition:
- Package lock_monitor_p: typedef enum logic [1:0] lock_state_e {UNLOCKED, ACQUIRING, LOCKED, RELEASING}.
- The lock_monitor_p package also holds localparam widths for CSR mapping of state_o.
- Sub-module dwell_timer (DWELL_WIDTH):
  - Inputs: inc, clr, target.
  - Output: match (dwell == target).
  - Instantiated once and shared by the ACQUIRING and RELEASING states.
- Top module: FSM, compares, event registers and the saturating loss counter.

Test Plan:
1. Reset with lock_th=100, unlock_th=60, acq_dwell=3, rel_dwell=2 -> all outputs 0. Drive count_i=120 from edge 0 -> state 1 at edge 0; locked_o=1 and lock_event_o pulse after edge 4; state 2.
2. Locked; count_i=50 for 2 cycles then 70 -> RELEASING then back to LOCKED; locked_o stays 1; no unlock_event_o; loss count 0.
3. Locked; count_i=50 held -> UNLOCKED after edge 3 from the first low sample; unlock_event_o one pulse; lock_loss_count_o=1.
4. acq_dwell=0: count_i=100 (equal to threshold) -> LOCKED after 2 edges. With count_i=99 the state stays UNLOCKED indefinitely.
5. Hold monitor_en_i=0 mid-ACQUIRING for 10 cycles -> state and dwell frozen; resume completes the remaining dwell. Assert clear_en_i while LOCKED -> UNLOCKED next edge, loss count 0, no events.
6. BIT_WIDTH=2: force 5 lock/unlock cycles -> lock_loss_count_o saturates at 3. Assert async reset mid-RELEASING -> outputs 0 immediately, without waiting for a clock edge.
